mem_access: RTL
===============

# mem_access

Memory-access stage controller between the EX/MEM latch and the MEM/WB latch. It turns the latched load/store controls into a registered request/`dhit` handshake with the data cache, and stalls the pipeline until the access completes. It presents the load result, or the SC result, to MEM/WB for exactly one cycle. It also owns the per-core LL/SC link register, which is invalidated by coherence snoops, and the sticky halt flag.

## Interface
- DATA_W, 32, data and address width; word-aligned, with link compare on bits [DATA_W-1:2]
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- valid_i  in  1  EX/MEM holds a live instruction
- ren_i / wen_i  in  1 / 1  load / store request from EX/MEM
- ll_i / sc_i  in  1 / 1  instruction is LL / SC; qualifies ren_i / wen_i
- halt_i  in  1  instruction is HALT
- addr_i  in  DATA_W  effective address (ALU result)
- store_i  in  DATA_W  store data
- dhit  in  1  cache completes the current request this cycle
- dmemload  in  DATA_W  load data, valid with dhit
- snoop_valid  in  1  another core is writing snoop_addr
- snoop_addr  in  DATA_W  snooped write address
- dmemREN / dmemWEN  out  1 / 1  registered cache read / write request
- dmemaddr / dmemstore  out  DATA_W  registered request address / data
- load_o  out  DATA_W  result to MEM/WB: load data, or 1/0 for SC
- stall_o  out  1  hold PC, IF/ID, ID/EX and EX/MEM; insert bubble into MEM/WB
- halt_o  out  1  sticky halt

## Operation
- A memory op is `memop = valid_i & (ren_i | wen_i) & !halt_o`.
- FSM states are IDLE, ACCESS and DONE.
- **IDLE**
  - If memop and not a failing SC: latch dmemaddr←addr_i and dmemstore←store_i. Set dmemWEN←wen_i and dmemREN←ren_i & !wen_i (write wins if both are set). Go to ACCESS.
  - A failing SC is sc_i & (!link_valid | link_addr[31:2] != addr_i[31:2]). It issues no request; load_o←0; go to DONE.
  - Otherwise stay in IDLE.
- **ACCESS**
  - Request outputs hold stable until dhit.
  - On dhit: drop dmemREN/dmemWEN and go to DONE.
  - load_o gets dmemload for a read, 1 for an SC write, and holds its value for a plain store.
- **DONE**
  - Stall is released; load_o is stable; go to IDLE.
- **Link register** (link_valid, link_addr) updates in ACCESS on dhit:
  - LL read sets link_valid and link_addr←dmemaddr.
  - SC write clears link_valid.
  - Plain store clears link_valid when dmemaddr[31:2] == link_addr[31:2].
- **Snoop**
  - When snoop_valid and snoop_addr[31:2] == link_addr[31:2], link_valid clears, in any state.
  - A snoop clear and an LL set on the same word in the same cycle leave link_valid = 0.
- **Halt**
  - valid_i & halt_i in IDLE sets halt_o, which stays set until reset.
  - After halt_o is set, no new requests are issued and stall_o = 0.
- `stall_o = (IDLE & memop) | ACCESS`.
  - It is 0 in DONE, so EX/MEM advances on the clock edge that ends DONE.
  - The instruction that follows is evaluated in IDLE the next cycle.

## Timing
- Reset values:
  - State is IDLE.
  - dmemREN, dmemWEN, dmemaddr, dmemstore, load_o, halt_o, link_valid and link_addr are all 0.
  - stall_o is 0 while nRST is low.
- Reset asserted mid-ACCESS drops the requests asynchronously. No partial write completes from this block.
- Request issue: requests are asserted the cycle after the op appears in IDLE.
- Load latency with a 1-cycle dhit:
  - cycle 0 is IDLE with stall;
  - cycle 1 is ACCESS with dhit;
  - cycle 2 is DONE, where load_o is valid and stall is low.
- Each further cycle of dhit delay adds one ACCESS cycle.
- Failing SC takes 2 cycles (IDLE→DONE) and produces no cache traffic.
- Non-memory instructions pass with zero added cycles and stall_o = 0.
- dhit outside ACCESS is ignored.
- load_o changes only when entering DONE.

## Test plan
- Load: LW 0x40, with dhit 3 cycles after the request and dmemload = 0xDEADBEEF.
  - dmemREN is high for 3 cycles with dmemaddr = 0x40.
  - stall_o is high for 4 cycles.
  - DONE shows load_o = 0xDEADBEEF.
- Store: SW 0x80 with store_i = 0x1234 and 1-cycle dhit → dmemWEN high for one cycle with dmemstore = 0x1234; stall_o is high for 2 cycles.
- LL/SC success: LL 0x100, then SC 0x100 → the SC issues a write and load_o = 1; link_valid ends at 0.
- LL/SC with a snoop in between: LL 0x100, then snoop_valid with snoop_addr = 0x102, then SC 0x100 → no dmemWEN; load_o = 0 after 2 cycles.
- Halt: HALT, then LW → halt_o = 1 and stays set; no dmemREN; stall_o = 0.
- Reset mid-ACCESS during a store → dmemWEN, state and all outputs return to 0 immediately; the next LW after release behaves normally.

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if: pipeline, data-cache and snoop signals of the memory-access stage.
interface mem_access_if #(parameter int DATA_W = 32);
   logic              valid_i, ren_i, wen_i, ll_i, sc_i, halt_i;
   logic [DATA_W-1:0] addr_i, store_i;
   logic              dhit;
   logic [DATA_W-1:0] dmemload;
   logic              snoop_valid;
   logic [DATA_W-1:0] snoop_addr;
   logic              dmemREN, dmemWEN;
   logic [DATA_W-1:0] dmemaddr, dmemstore, load_o;
   logic              stall_o, halt_o;
   modport master (
      input  valid_i, ren_i, wen_i, ll_i, sc_i, halt_i, addr_i, store_i,
      input  dhit, dmemload, snoop_valid, snoop_addr,
      output dmemREN, dmemWEN, dmemaddr, dmemstore, load_o, stall_o, halt_o
   );
   modport slave (
      output valid_i, ren_i, wen_i, ll_i, sc_i, halt_i, addr_i, store_i,
      output dhit, dmemload, snoop_valid, snoop_addr,
      input  dmemREN, dmemWEN, dmemaddr, dmemstore, load_o, stall_o, halt_o
   );
endinterface

// File: rtl/mem_access.sv
// mem_access: MEM-stage controller issuing registered cache requests, stalling until dhit,
// and owning the LL/SC link register and the sticky halt flag.
module mem_access #(parameter int DATA_W = 32) (
   input logic CLK,
   input logic nRST,
   mem_access_if.master bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state, next_state;
   logic memop, sc_fail, ll_q, sc_q, link_valid, ll_set, wr_clr, snoop_clr, unused_ok;
   logic [DATA_W-1:0] link_addr, link_nxt;
   assign memop     = bus.valid_i & (bus.ren_i | bus.wen_i) & ~bus.halt_o;
   assign sc_fail   = bus.sc_i & (~link_valid | (link_addr[DATA_W-1:2] != bus.addr_i[DATA_W-1:2]));
   assign ll_set    = (state == ACCESS) & bus.dhit & bus.dmemREN & ll_q;
   assign wr_clr    = (state == ACCESS) & bus.dhit & bus.dmemWEN &
                      (sc_q | (bus.dmemaddr[DATA_W-1:2] == link_addr[DATA_W-1:2]));
   // Snoop compares against the address being linked this cycle, so a same-cycle LL loses
   assign link_nxt  = ll_set ? bus.dmemaddr : link_addr;
   assign snoop_clr = bus.snoop_valid & (bus.snoop_addr[DATA_W-1:2] == link_nxt[DATA_W-1:2]);
   assign unused_ok = ^{bus.snoop_addr[1:0], link_addr[1:0]};
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end
   always_comb begin
      next_state  = IDLE;
      bus.stall_o = 1'b0;
      case (state)
         IDLE: begin
            next_state  = memop ? (sc_fail ? DONE : ACCESS) : IDLE;
            bus.stall_o = memop & nRST;
         end
         ACCESS: begin
            next_state  = bus.dhit ? DONE : ACCESS;
            bus.stall_o = nRST;
         end
         default: next_state = IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         bus.dmemREN   <= 1'b0;
         bus.dmemWEN   <= 1'b0;
         bus.dmemaddr  <= '0;
         bus.dmemstore <= '0;
         bus.load_o    <= '0;
         bus.halt_o    <= 1'b0;
         ll_q          <= 1'b0;
         sc_q          <= 1'b0;
         link_valid    <= 1'b0;
         link_addr     <= '0;
      end else begin
         link_valid <= (link_valid | ll_set) & ~wr_clr & ~snoop_clr;
         link_addr  <= link_nxt;
         if (state == IDLE && bus.valid_i && bus.halt_i) bus.halt_o <= 1'b1;
         if (state == IDLE && memop) begin
            if (sc_fail) bus.load_o <= '0;
            else begin
               bus.dmemaddr  <= bus.addr_i;
               bus.dmemstore <= bus.store_i;
               bus.dmemWEN   <= bus.wen_i;
               bus.dmemREN   <= bus.ren_i & ~bus.wen_i;
               ll_q          <= bus.ll_i;
               sc_q          <= bus.sc_i;
            end
         end
         if (state == ACCESS && bus.dhit) begin
            bus.dmemREN <= 1'b0;
            bus.dmemWEN <= 1'b0;
            if (bus.dmemREN) bus.load_o <= bus.dmemload;
            else if (sc_q)   bus.load_o <= DATA_W'(1);
         end
      end
   end
endmodule
